mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single pipelined main-memory port between the I-cache fill FSM and the D-cache fill FSM, plus D-cache write-through stores.
- Grants the port for a whole block burst (8 words, 16-bit).
- Holds the losing fill FSM with its pause input.
- Routes memory_data_vld only to the granted side.
- Sits between both caches' fill FSMs and the main-memory model.

Parameters:
BURST_LEN, 8, number of memory_data_vld pulses that complete one block fill
CNT_W, 4, width of the returned-word counter (must hold BURST_LEN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
i_busy  input  1  I-cache fill FSM busy (miss being serviced)
i_read_req  input  1  I-cache fill FSM read request
i_addr  input  16  I-cache fill FSM memory_address
i_pause  output  1  to I-cache fill FSM pause
i_data_vld  output  1  memory_data_vld gated to I-cache
d_busy  input  1  D-cache fill FSM busy
d_read_req  input  1  D-cache fill FSM read request
d_addr  input  16  D-cache memory_address (fill or store address)
d_wrt  input  1  D-cache write-through store request (wrt_mem)
d_wdata  input  16  store data
d_pause  output  1  to D-cache fill FSM pause
d_data_vld  output  1  memory_data_vld gated to D-cache
d_wrt_stall  output  1  store cannot issue this cycle; pipeline must stall
mem_addr  output  16  address to main memory
mem_enable  output  1  main-memory access enable
mem_wr  output  1  main-memory write enable
mem_wdata  output  16  main-memory write data
mem_data_vld  input  1  main-memory read data valid

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state = IDLE, vld_cnt = 0, last_grant = I.
  - All outputs 0, except i_pause/d_pause, which follow the rules below. They are 0 in the reset cycle when busy inputs are 0.
- States:
  - IDLE: no grant.
  - GNT_I: I-cache owns the port.
  - GNT_D: D-cache owns the port.
- IDLE:
  - i_pause = i_busy and d_pause = d_busy, so the first request cycle is a hold cycle.
  - mem_enable/mem_wr/mem_wdata/mem_addr pass d_wrt/d_wrt/d_wdata/d_addr combinationally; d_wrt_stall = 0.
  - Next state:
    - only d_busy -> GNT_D
    - only i_busy -> GNT_I
    - both -> the side not equal to last_grant
    - neither -> IDLE.
  - d_wrt and d_busy together in IDLE do not occur (D FSM never stores while missing); the store has priority for that cycle.
- GNT_x (x = granted side, y = other side):
  - mem_addr = x_addr; mem_enable = x_read_req; mem_wr = 0.
  - x_pause = 0; y_pause = y_busy.
  - x_data_vld = mem_data_vld; y_data_vld = 0.
  - d_wrt_stall = d_wrt.
  - Each mem_data_vld increments vld_cnt.
  - When mem_data_vld arrives with vld_cnt == BURST_LEN-1:
    - vld_cnt -> 0, last_grant <= x, next state IDLE.
    - The other side is granted after its IDLE hold cycle: hand-off costs exactly one IDLE cycle.
  - Abort: if x_busy drops before the burst completes, return to IDLE next cycle, vld_cnt -> 0, last_grant <= x. Late mem_data_vld pulses after the abort go to neither side.
- mem_data_vld in IDLE is dropped; i_data_vld = d_data_vld = 0.
- Gating: i_data_vld and d_data_vld are never both 1. Neither is ever 1 outside its own grant state.
- Reset mid-burst:
  - Next cycle, state = IDLE and vld_cnt = 0.
  - Outputs follow the IDLE rules; no vld is forwarded.
- Pause timing: pause is combinational from state and busy. A paused FSM freezes its counter in the same cycle.

Test Plan:
1. Reset, then i_busy=1 for one burst; mem_data_vld pulses on 8 cycles -> IDLE 1 cycle with i_pause=1; then GNT_I; i_data_vld mirrors all 8 pulses; IDLE the cycle after the 8th; d_data_vld stays 0.
2. i_busy and d_busy rise on the same cycle after reset -> D granted first, i_pause=1 throughout the D burst plus one IDLE cycle; I is then granted; 16 total vld pulses split 8/8.
3. During GNT_I, d_wrt=1 with d_addr=0x1234, d_wdata=0xBEEF -> d_wrt_stall=1 and mem_wr=0 until the burst ends. In the IDLE cycle, mem_wr=1, mem_addr=0x1234, mem_wdata=0xBEEF, d_wrt_stall=0.
4. Back-to-back contention: D holds d_busy continuously, I misses during the D burst -> after the D burst completes, I is granted next (last_grant=D), not D again.
5. Abort: i_busy drops after 3 vld pulses -> IDLE next cycle, vld_cnt=0. The next D request completes a full 8-pulse burst.
6. rst asserted after 5 vld pulses in GNT_D -> next cycle IDLE, all data_vld outputs 0; a fresh D request needs a full 8 pulses to complete.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory signals around the arbiter.
// slave = arbiter view, master = the caches/memory side driving the requests.
interface mem_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              i_busy;
    logic              i_read_req;
    logic [DATA_W-1:0] i_addr;
    logic              i_pause;
    logic              i_data_vld;

    logic              d_busy;
    logic              d_read_req;
    logic [DATA_W-1:0] d_addr;
    logic              d_wrt;
    logic [DATA_W-1:0] d_wdata;
    logic              d_pause;
    logic              d_data_vld;
    logic              d_wrt_stall;

    logic [DATA_W-1:0] mem_addr;
    logic              mem_enable;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_data_vld;

    modport slave (
        input  i_busy, i_read_req, i_addr,
        output i_pause, i_data_vld,
        input  d_busy, d_read_req, d_addr, d_wrt, d_wdata,
        output d_pause, d_data_vld, d_wrt_stall,
        output mem_addr, mem_enable, mem_wr, mem_wdata,
        input  mem_data_vld
    );

    modport master (
        output i_busy, i_read_req, i_addr,
        input  i_pause, i_data_vld,
        output d_busy, d_read_req, d_addr, d_wrt, d_wdata,
        input  d_pause, d_data_vld, d_wrt_stall,
        input  mem_addr, mem_enable, mem_wr, mem_wdata,
        output mem_data_vld
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single pipelined main-memory port between the I-cache and D-cache
// fill FSMs (granted per whole block burst) and D-cache write-through stores.
module mem_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] vld_cnt;
    logic [CNT_W-1:0] vld_cnt_nxt;
    logic             last_grant;
    logic             last_grant_nxt;
    logic             own_busy;
    logic             burst_done;

    always_comb begin
        own_busy = 1'b0;
        case (state)
            GNT_I:   own_busy = bus.i_busy;
            GNT_D:   own_busy = bus.d_busy;
            default: own_busy = 1'b0;
        endcase
    end

    assign burst_done = bus.mem_data_vld && (vld_cnt == LAST_CNT);

    // Grant stays for the whole burst; on contention the side that did not
    // own the port last time wins, so back-to-back misses alternate.
    always_comb begin
        state_nxt      = state;
        vld_cnt_nxt    = vld_cnt;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                vld_cnt_nxt = '0;
                if (bus.i_busy && bus.d_busy) begin
                    state_nxt = (last_grant == SIDE_I) ? GNT_D : GNT_I;
                end else if (bus.d_busy) begin
                    state_nxt = GNT_D;
                end else if (bus.i_busy) begin
                    state_nxt = GNT_I;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GNT_I, GNT_D: begin
                if (!own_busy || burst_done) begin
                    state_nxt      = IDLE;
                    vld_cnt_nxt    = '0;
                    last_grant_nxt = (state == GNT_D) ? SIDE_D : SIDE_I;
                end else if (bus.mem_data_vld) begin
                    vld_cnt_nxt = vld_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                vld_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vld_cnt    <= '0;
            last_grant <= SIDE_I;
        end else begin
            state      <= state_nxt;
            vld_cnt    <= vld_cnt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // In IDLE the port belongs to the write-through store path; pauses are
    // combinational so a held FSM freezes in the same cycle it is refused.
    always_comb begin
        bus.i_pause     = 1'b0;
        bus.d_pause     = 1'b0;
        bus.i_data_vld  = 1'b0;
        bus.d_data_vld  = 1'b0;
        bus.d_wrt_stall = 1'b0;
        bus.mem_addr    = bus.d_addr;
        bus.mem_wdata   = bus.d_wdata;
        bus.mem_enable  = 1'b0;
        bus.mem_wr      = 1'b0;
        case (state)
            IDLE: begin
                bus.i_pause    = bus.i_busy;
                bus.d_pause    = bus.d_busy;
                bus.mem_enable = bus.d_wrt;
                bus.mem_wr     = bus.d_wrt;
            end
            GNT_I: begin
                bus.mem_addr    = bus.i_addr;
                bus.mem_enable  = bus.i_read_req;
                bus.d_pause     = bus.d_busy;
                bus.i_data_vld  = bus.mem_data_vld;
                bus.d_wrt_stall = bus.d_wrt;
            end
            GNT_D: begin
                bus.mem_addr    = bus.d_addr;
                bus.mem_enable  = bus.d_read_req;
                bus.i_pause     = bus.i_busy;
                bus.d_data_vld  = bus.mem_data_vld;
                bus.d_wrt_stall = bus.d_wrt;
            end
            default: begin
                bus.i_pause = bus.i_busy;
                bus.d_pause = bus.d_busy;
            end
        endcase
    end

    a_vld_mutex: assert property (@(posedge clk) !(bus.i_data_vld && bus.d_data_vld));
    a_i_vld_own: assert property (@(posedge clk) bus.i_data_vld |-> (state == GNT_I));
    a_d_vld_own: assert property (@(posedge clk) bus.d_data_vld |-> (state == GNT_D));
    a_wr_idle:   assert property (@(posedge clk) bus.mem_wr |-> (state == IDLE));
    a_cnt_range: assert property (@(posedge clk) disable iff (rst) vld_cnt <= LAST_CNT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter: per-cycle stimulus/expectation records,
// expectations queued on drive and compared when outputs settle.
module tb_mem_arbiter;
    localparam logic [15:0] IA = 16'h0100;
    localparam logic [15:0] DA = 16'h0200;
    localparam logic [15:0] SA = 16'h1234;
    localparam logic [15:0] SD = 16'hBEEF;

    typedef struct {
        logic        rst;
        logic        i_busy;
        logic        i_rd;
        logic [15:0] i_addr;
        logic        d_busy;
        logic        d_rd;
        logic [15:0] d_addr;
        logic        d_wrt;
        logic [15:0] d_wdata;
        logic        mvld;
    } stim_t;

    typedef struct {
        logic        i_pause;
        logic        i_vld;
        logic        d_pause;
        logic        d_vld;
        logic        stall;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } exp_t;

    typedef struct {
        string tag;
        stim_t s;
        exp_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if bus ();

    mem_arbiter #(.BURST_LEN(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t  tbl[$];
    exp_t  sb[$];
    string sb_tag[$];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic stim_t S(logic r, logic ib, logic db, logic mv);
        stim_t s;
        s.rst     = r;
        s.i_busy  = ib;
        s.i_rd    = ib;
        s.i_addr  = IA;
        s.d_busy  = db;
        s.d_rd    = db;
        s.d_addr  = DA;
        s.d_wrt   = 1'b0;
        s.d_wdata = 16'h0000;
        s.mvld    = mv;
        return s;
    endfunction

    function automatic stim_t SW(logic ib, logic mv);
        stim_t s;
        s         = S(1'b0, ib, 1'b0, mv);
        s.d_wrt   = 1'b1;
        s.d_addr  = SA;
        s.d_wdata = SD;
        return s;
    endfunction

    function automatic exp_t E(logic ip, logic iv, logic dp, logic dv, logic st,
                               logic en, logic wr, logic [15:0] addr, logic [15:0] wd);
        exp_t e;
        e.i_pause = ip;
        e.i_vld   = iv;
        e.d_pause = dp;
        e.d_vld   = dv;
        e.stall   = st;
        e.en      = en;
        e.wr      = wr;
        e.addr    = addr;
        e.wdata   = wd;
        return e;
    endfunction

    task automatic add(input string t, input stim_t s, input exp_t e);
        vec_t v;
        v.tag = t;
        v.s   = s;
        v.e   = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input stim_t s);
        rst              = s.rst;
        bus.i_busy       = s.i_busy;
        bus.i_read_req   = s.i_rd;
        bus.i_addr       = s.i_addr;
        bus.d_busy       = s.d_busy;
        bus.d_read_req   = s.d_rd;
        bus.d_addr       = s.d_addr;
        bus.d_wrt        = s.d_wrt;
        bus.d_wdata      = s.d_wdata;
        bus.mem_data_vld = s.mvld;
    endtask

    task automatic check();
        exp_t        e;
        string       t;
        logic [38:0] got;
        logic [38:0] want;
        e = sb.pop_front();
        t = sb_tag.pop_front();
        got  = {bus.i_pause, bus.i_data_vld, bus.d_pause, bus.d_data_vld, bus.d_wrt_stall,
                bus.mem_enable, bus.mem_wr, bus.mem_addr, (e.wr ? bus.mem_wdata : 16'h0000)};
        want = {e.i_pause, e.i_vld, e.d_pause, e.d_vld, e.stall,
                e.en, e.wr, e.addr, (e.wr ? e.wdata : 16'h0000)};
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got {ip,iv,dp,dv,stall,en,wr,addr,wdata}=%h required %h", t, got, want);
        end
    endtask

    // Drive at posedge+1, compare at the following negedge, then advance.
    task automatic step(input string t, input stim_t s, input exp_t e);
        drive(s);
        sb.push_back(e);
        sb_tag.push_back(t);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        logic       mv;
        logic       ib;

        // Test 1: single I burst with gaps between pulses.
        pat = 10'b1111101101;
        add("reset", S(1, 0, 0, 0), E(0, 0, 0, 0, 0, 0, 0, DA, 16'h0));
        add("t1_hold", S(0, 1, 0, 0), E(1, 0, 0, 0, 0, 0, 0, DA, 16'h0));
        for (int k = 0; k < 10; k++) begin
            mv = pat[k];
            add($sformatf("t1_iburst%0d", k), S(0, 1, 0, mv), E(0, mv, 0, 0, 0, 1, 0, IA, 16'h0));
        end
        add("t1_idle_drop", S(0, 0, 0, 1), E(0, 0, 0, 0, 0, 0, 0, DA, 16'h0));

        // Test 2: simultaneous requests, D first since last_grant resets to I.
        add("t2_hold", S(0, 1, 1, 0), E(1, 0, 1, 0, 0, 0, 0, DA, 16'h0));
        for (int k = 0; k < 8; k++)
            add($sformatf("t2_dburst%0d", k), S(0, 1, 1, 1), E(1, 0, 0, 1, 0, 1, 0, DA, 16'h0));
        add("t2_handoff", S(0, 1, 0, 0), E(1, 0, 0, 0, 0, 0, 0, DA, 16'h0));
        for (int k = 0; k < 8; k++)
            add($sformatf("t2_iburst%0d", k), S(0, 1, 0, 1), E(0, 1, 0, 0, 0, 1, 0, IA, 16'h0));

        // Test 3: store during an I burst stalls, then issues in IDLE.
        add("t3_hold", S(0, 1, 0, 0), E(1, 0, 0, 0, 0, 0, 0, DA, 16'h0));
        for (int k = 0; k < 8; k++)
            add($sformatf("t3_stall%0d", k), SW(1, 1), E(0, 1, 0, 0, 1, 1, 0, IA, 16'h0));
        add("t3_store", SW(0, 0), E(0, 0, 0, 0, 0, 1, 1, SA, SD));

        // Test 4: I misses during a D burst, D stays busy; I must win next.
        add("t4_hold", S(0, 0, 1, 0), E(0, 0, 1, 0, 0, 0, 0, DA, 16'h0));
        for (int k = 0; k < 8; k++) begin
            ib = (k >= 2);
            add($sformatf("t4_dburst%0d", k), S(0, ib, 1, 1), E(ib, 0, 0, 1, 0, 1, 0, DA, 16'h0));
        end
        add("t4_idle_both", S(0, 1, 1, 0), E(1, 0, 1, 0, 0, 0, 0, DA, 16'h0));
        for (int k = 0; k < 8; k++)
            add($sformatf("t4_inext%0d", k), S(0, 1, 1, 1), E(0, 1, 1, 0, 0, 1, 0, IA, 16'h0));
        add("t4_idle", S(0, 0, 0, 0), E(0, 0, 0, 0, 0, 0, 0, DA, 16'h0));

        rst = 1'b1;
        drive(S(1, 0, 0, 0));
        @(posedge clk);
        #1;
        foreach (tbl[i]) step(tbl[i].tag, tbl[i].s, tbl[i].e);

        // Test 5: abort after 3 pulses; the count must restart for D.
        step("t5_hold", S(0, 1, 0, 0), E(1, 0, 0, 0, 0, 0, 0, DA, 16'h0));
        for (int k = 0; k < 3; k++)
            step("t5_ipulse", S(0, 1, 0, 1), E(0, 1, 0, 0, 0, 1, 0, IA, 16'h0));
        step("t5_abort", S(0, 0, 0, 0), E(0, 0, 0, 0, 0, 0, 0, IA, 16'h0));
        step("t5_late_drop", S(0, 0, 1, 1), E(0, 0, 1, 0, 0, 0, 0, DA, 16'h0));
        for (int k = 0; k < 7; k++)
            step($sformatf("t5_dpulse%0d", k), S(0, 0, 1, 1), E(0, 0, 0, 1, 0, 1, 0, DA, 16'h0));
        step("t5_dgap", S(0, 0, 1, 0), E(0, 0, 0, 0, 0, 1, 0, DA, 16'h0));
        step("t5_dlast", S(0, 0, 1, 1), E(0, 0, 0, 1, 0, 1, 0, DA, 16'h0));
        step("t5_end", S(0, 0, 0, 0), E(0, 0, 0, 0, 0, 0, 0, DA, 16'h0));

        // Test 6: reset after 5 pulses of a D burst.
        step("t6_hold", S(0, 0, 1, 0), E(0, 0, 1, 0, 0, 0, 0, DA, 16'h0));
        for (int k = 0; k < 5; k++)
            step("t6_dpulse", S(0, 0, 1, 1), E(0, 0, 0, 1, 0, 1, 0, DA, 16'h0));
        step("t6_rst", S(1, 0, 1, 0), E(0, 0, 0, 0, 0, 1, 0, DA, 16'h0));
        step("t6_after_rst", S(0, 0, 1, 1), E(0, 0, 1, 0, 0, 0, 0, DA, 16'h0));
        for (int k = 0; k < 7; k++)
            step($sformatf("t6_dpulse%0d", k), S(0, 0, 1, 1), E(0, 0, 0, 1, 0, 1, 0, DA, 16'h0));
        step("t6_dgap", S(0, 0, 1, 0), E(0, 0, 0, 0, 0, 1, 0, DA, 16'h0));
        step("t6_dlast", S(0, 0, 1, 1), E(0, 0, 0, 1, 0, 1, 0, DA, 16'h0));
        step("t6_end", S(0, 0, 0, 0), E(0, 0, 0, 0, 0, 0, 0, DA, 16'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
